// File: rtl/sad_window_engine_pkg.sv
// Shared types and constants for the SAD window engine.
package sad_window_engine_pkg;

  localparam int PIX_W      = 8;
  localparam int LANES      = 4;
  localparam int WORD_W     = 32;
  localparam int LANE_SUM_W = PIX_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACCUM,
    ST_DONE
  } sad_state_e;

  function automatic logic [PIX_W-1:0] absdiff8(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sad_window_engine_if.sv
// Command, result and BRAM-read signals of the SAD window engine.
// master = engine side, slave = host / read-interface side.
interface sad_window_engine_if #(parameter int SAD_W = 16) ();
  import sad_window_engine_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [WORD_W-1:0] cmd_left_base;
  logic [WORD_W-1:0] cmd_right_base;

  logic [WORD_W-1:0] sad_left_bram_addr;
  logic [WORD_W-1:0] sad_right_bram_addr;
  logic              sad_start_read;
  logic [WORD_W-1:0] l_camera_read_data;
  logic [WORD_W-1:0] r_camera_read_data;
  logic              bram_complete;

  logic              res_valid;
  logic              res_ready;
  logic [SAD_W-1:0]  res_sad;
  logic              res_err;

  modport master (
    input  cmd_valid, cmd_left_base, cmd_right_base,
    output cmd_ready,
    output sad_left_bram_addr, sad_right_bram_addr, sad_start_read,
    input  l_camera_read_data, r_camera_read_data, bram_complete,
    output res_valid, res_sad, res_err,
    input  res_ready
  );

  modport slave (
    output cmd_valid, cmd_left_base, cmd_right_base,
    input  cmd_ready,
    input  sad_left_bram_addr, sad_right_bram_addr, sad_start_read,
    output l_camera_read_data, r_camera_read_data, bram_complete,
    input  res_valid, res_sad, res_err,
    output res_ready
  );

endinterface

// File: rtl/sad_window_engine_absdiff4.sv
// Four-lane sum of absolute byte differences of two packed words.
module sad_absdiff4
  import sad_window_engine_pkg::*;
(
  input  logic [WORD_W-1:0]     a,
  input  logic [WORD_W-1:0]     b,
  output logic [LANE_SUM_W-1:0] sum
);

  // Lane sums never exceed 4*255, so the 10-bit result cannot overflow.
  always_comb begin
    sum = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = sum + LANE_SUM_W'(absdiff8(a[k*PIX_W +: PIX_W], b[k*PIX_W +: PIX_W]));
    end
  end

endmodule

// File: rtl/sad_window_engine.sv
// Issues one BRAM word read per window word and accumulates the SAD.
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_ISSUE | addresses valid, one-cycle sad_start_read pulse
// ST_WAIT  | waiting for bram_complete, timeout counter running
// ST_ACCUM | add the word's lane sum, advance or finish
// ST_DONE  | result presented until res_ready
module sad_window_engine
  import sad_window_engine_pkg::*;
#(
  parameter int WORDS   = 16,
  parameter int STRIDE  = 4,
  parameter int SAD_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                axi_clk,
  input  logic                axi_rst,
  sad_window_engine_if.master bus,
  output logic                busy
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  sad_state_e state, state_nxt;

  logic [IDX_W-1:0]      idx;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [SAD_W-1:0]      acc;
  logic [WORD_W-1:0]     addr_l, addr_r;
  logic [WORD_W-1:0]     l_q, r_q;
  logic                  err_q;
  logic [LANE_SUM_W-1:0] lane_sum;

  sad_absdiff4 u_absdiff (
    .a   (l_q),
    .b   (r_q),
    .sum (lane_sum)
  );

  assign bus.sad_left_bram_addr  = addr_l;
  assign bus.sad_right_bram_addr = addr_r;
  assign bus.res_sad             = acc;
  assign bus.res_err             = err_q;

  // State register.
  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt          = state;
    bus.cmd_ready      = 1'b0;
    bus.sad_start_read = 1'b0;
    bus.res_valid      = 1'b0;
    busy               = 1'b1;
    case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
        if (bus.cmd_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        bus.sad_start_read = 1'b1;
        state_nxt          = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.bram_complete)   state_nxt = ST_ACCUM;
        else if (tmo_cnt == '0)  state_nxt = ST_DONE;
      end
      ST_ACCUM: begin
        state_nxt = (idx == IDX_LAST) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: addresses advance by STRIDE per word (wrapping mod 2^32),
  // the timeout is a down-counter reloaded on every issue.
  always_ff @(posedge axi_clk or negedge axi_rst) begin
    if (!axi_rst) begin
      idx     <= '0;
      tmo_cnt <= '0;
      acc     <= '0;
      addr_l  <= '0;
      addr_r  <= '0;
      l_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            addr_l <= bus.cmd_left_base;
            addr_r <= bus.cmd_right_base;
            idx    <= '0;
            acc    <= '0;
            err_q  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= TMO_W'(TIMEOUT - 1);
        end
        ST_WAIT: begin
          if (bus.bram_complete) begin
            l_q <= bus.l_camera_read_data;
            r_q <= bus.r_camera_read_data;
          end else if (tmo_cnt == '0) begin
            err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        ST_ACCUM: begin
          acc <= acc + SAD_W'(lane_sum);
          if (idx != IDX_LAST) begin
            idx    <= idx + IDX_W'(1);
            addr_l <= addr_l + WORD_W'(STRIDE);
            addr_r <= addr_r + WORD_W'(STRIDE);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_window_engine.sv
// Bench for sad_window_engine: a WORDS=4 instance (index 0) and a
// WORDS=16 instance (index 1) share a behavioural BRAM responder.
module tb_sad_window_engine;

  logic axi_clk;
  logic rst_n;

  sad_window_engine_if #(.SAD_W(16)) bus_a ();
  sad_window_engine_if #(.SAD_W(16)) bus_b ();

  logic busy_w [2];

  sad_window_engine #(.WORDS(4), .STRIDE(4), .SAD_W(16), .TIMEOUT(64)) dut_a (
    .axi_clk (axi_clk),
    .axi_rst (rst_n),
    .bus     (bus_a),
    .busy    (busy_w[0])
  );

  sad_window_engine #(.WORDS(16), .STRIDE(4), .SAD_W(16), .TIMEOUT(64)) dut_b (
    .axi_clk (axi_clk),
    .axi_rst (rst_n),
    .bus     (bus_b),
    .busy    (busy_w[1])
  );

  // Host/responder drive arrays, index = instance.
  logic        cv [2];
  logic [31:0] clb [2];
  logic [31:0] crb [2];
  logic        rr [2];
  logic        cplt [2];
  logic [31:0] ld [2];
  logic [31:0] rd [2];

  logic        cr_w [2];
  logic        start_w [2];
  logic [31:0] al_w [2];
  logic [31:0] ar_w [2];
  logic        rv_w [2];
  logic [15:0] rs_w [2];
  logic        re_w [2];

  assign bus_a.cmd_valid = cv[0];
  assign bus_a.cmd_left_base = clb[0];
  assign bus_a.cmd_right_base = crb[0];
  assign bus_a.res_ready = rr[0];
  assign bus_a.bram_complete = cplt[0];
  assign bus_a.l_camera_read_data = ld[0];
  assign bus_a.r_camera_read_data = rd[0];
  assign bus_b.cmd_valid = cv[1];
  assign bus_b.cmd_left_base = clb[1];
  assign bus_b.cmd_right_base = crb[1];
  assign bus_b.res_ready = rr[1];
  assign bus_b.bram_complete = cplt[1];
  assign bus_b.l_camera_read_data = ld[1];
  assign bus_b.r_camera_read_data = rd[1];

  assign cr_w[0] = bus_a.cmd_ready;
  assign start_w[0] = bus_a.sad_start_read;
  assign al_w[0] = bus_a.sad_left_bram_addr;
  assign ar_w[0] = bus_a.sad_right_bram_addr;
  assign rv_w[0] = bus_a.res_valid;
  assign rs_w[0] = bus_a.res_sad;
  assign re_w[0] = bus_a.res_err;
  assign cr_w[1] = bus_b.cmd_ready;
  assign start_w[1] = bus_b.sad_start_read;
  assign al_w[1] = bus_b.sad_left_bram_addr;
  assign ar_w[1] = bus_b.sad_right_bram_addr;
  assign rv_w[1] = bus_b.res_valid;
  assign rs_w[1] = bus_b.res_sad;
  assign re_w[1] = bus_b.res_err;

  int checks = 0;
  int errors = 0;

  // Behavioural memory: byte address -> word; unwritten words read as 0.
  logic [31:0] lmem [logic [31:0]];
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] seen_l [$];
  logic [31:0] seen_r [$];
  int          nstart [2];
  int          cnt [2];
  logic [31:0] pa_l [2];
  logic [31:0] pa_r [2];
  int          word_no = 0;
  int          withhold = -1;

  function automatic logic [31:0] rd_l(input logic [31:0] a);
    if (lmem.exists(a)) return lmem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rd_r(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return 32'h0;
  endfunction

  // Reference: plain byte-wise absolute differences over n words.
  function automatic int model_sad(input logic [31:0] lb, input logic [31:0] rb, input int n);
    int s = 0;
    for (int k = 0; k < n; k++) begin
      logic [31:0] lw = rd_l(lb + 32'(4 * k));
      logic [31:0] rw = rd_r(rb + 32'(4 * k));
      for (int b = 0; b < 4; b++) begin
        int x = int'(lw[8*b +: 8]);
        int y = int'(rw[8*b +: 8]);
        s += (x > y) ? (x - y) : (y - x);
      end
    end
    return s;
  endfunction

  initial begin
    axi_clk = 1'b0;
    forever #5 axi_clk = ~axi_clk;
  end

  // Read responder: answers each start pulse after 0..2 extra cycles,
  // except the word selected by 'withhold', which never completes.
  initial begin
    for (int i = 0; i < 2; i++) begin
      cplt[i] = 1'b0; ld[i] = '0; rd[i] = '0; cnt[i] = -1; nstart[i] = 0;
    end
    forever begin
      @(negedge axi_clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          cplt[i] = 1'b0;
          cnt[i] = -1;
        end else begin
          if (cplt[i]) cplt[i] = 1'b0;
          else if (cnt[i] > 0) cnt[i]--;
          else if (cnt[i] == 0) begin
            cplt[i] = 1'b1;
            ld[i] = rd_l(pa_l[i]);
            rd[i] = rd_r(pa_r[i]);
            cnt[i] = -1;
          end
          if (start_w[i]) begin
            seen_l.push_back(al_w[i]);
            seen_r.push_back(ar_w[i]);
            pa_l[i] = al_w[i];
            pa_r[i] = ar_w[i];
            if (word_no != withhold) cnt[i] = $urandom_range(0, 2);
            word_no++;
            nstart[i]++;
          end
        end
      end
    end
  end

  task automatic fill_const(input logic [31:0] lb, input logic [31:0] rb, input int n,
                            input logic [31:0] lv, input logic [31:0] rv);
    for (int k = 0; k < n; k++) begin
      lmem[lb + 32'(4 * k)] = lv;
      rmem[rb + 32'(4 * k)] = rv;
    end
  endtask

  task automatic fill_rand(input logic [31:0] lb, input logic [31:0] rb, input int n,
                           input bit same);
    for (int k = 0; k < n; k++) begin
      logic [31:0] w = $urandom;
      lmem[lb + 32'(4 * k)] = w;
      rmem[rb + 32'(4 * k)] = same ? w : $urandom;
    end
  endtask

  function automatic logic [31:0] rand_base();
    logic [31:0] b = $urandom;
    return b & 32'hFFFF_FFFC;
  endfunction

  task automatic clear_log(input int d);
    seen_l.delete();
    seen_r.delete();
    nstart[d] = 0;
    word_no = 0;
  endtask

  task automatic send_cmd(input int d, input logic [31:0] lb, input logic [31:0] rb);
    clear_log(d);
    @(negedge axi_clk);
    cv[d] = 1'b1; clb[d] = lb; crb[d] = rb;
    @(negedge axi_clk);
    cv[d] = 1'b0; clb[d] = $urandom; crb[d] = $urandom;
  endtask

  task automatic wait_result(input int d, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (rv_w[d]) begin ok = 1'b1; break; end
      @(negedge axi_clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge axi_clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({cr_w[d], busy_w[d], start_w[d], rv_w[d], re_w[d]} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_flags dut%0d: got ready/busy/start/valid/err=%b%b%b%b%b want 10000",
                 d, cr_w[d], busy_w[d], start_w[d], rv_w[d], re_w[d]);
      end
      checks++;
      if (al_w[d] !== 32'h0 || ar_w[d] !== 32'h0 || rs_w[d] !== 16'h0) begin
        errors++;
        $display("FAIL reset_values dut%0d: got addr_l=%h addr_r=%h sad=%0d want 0/0/0",
                 d, al_w[d], ar_w[d], rs_w[d]);
      end
    end
    rst_n = 1'b1;
    @(negedge axi_clk);
  endtask

  task automatic test_basic_w4();
    logic [31:0] lb = rand_base();
    logic [31:0] rb = rand_base();
    bit ok;
    fill_const(lb, rb, 4, 32'h1010_1010, 32'h0808_0808);
    send_cmd(0, lb, rb);
    wait_result(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_w4_timeout: no res_valid"); end
    checks++;
    if (rs_w[0] !== 16'd128 || re_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_w4_sad: got sad=%0d err=%b want 128 err=0", rs_w[0], re_w[0]);
    end
    checks++;
    if (seen_l.size() != 4 || nstart[0] != 4) begin
      errors++;
      $display("FAIL basic_w4_pulses: got %0d pulses want 4", nstart[0]);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (seen_l[k] !== lb + 32'(4 * k) || seen_r[k] !== rb + 32'(4 * k)) begin
          errors++;
          $display("FAIL basic_w4_addr%0d: got %h/%h want %h/%h", k, seen_l[k], seen_r[k],
                   lb + 32'(4 * k), rb + 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_max_w16();
    logic [31:0] lb = rand_base();
    logic [31:0] rb = rand_base();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) fill_const(lb, rb, 16, 32'hFFFF_FFFF, 32'h0000_0000);
      else           fill_const(lb, rb, 16, 32'h0000_0000, 32'hFFFF_FFFF);
      send_cmd(1, lb, rb);
      wait_result(1, ok);
      checks++;
      if (!ok || rs_w[1] !== 16'd16320 || re_w[1] !== 1'b0) begin
        errors++;
        $display("FAIL max_w16_pass%0d: got sad=%0d err=%b ok=%0d want 16320 err=0",
                 pass, rs_w[1], re_w[1], ok);
      end
    end
  endtask

  task automatic test_identical();
    logic [31:0] lb = rand_base();
    logic [31:0] rb = rand_base();
    bit ok;
    fill_rand(lb, rb, 16, 1'b1);
    send_cmd(1, lb, rb);
    wait_result(1, ok);
    checks++;
    if (!ok || rs_w[1] !== 16'd0) begin
      errors++;
      $display("FAIL identical_sad: got %0d ok=%0d want 0", rs_w[1], ok);
    end
    checks++;
    if (nstart[1] != 16) begin
      errors++;
      $display("FAIL identical_pulses: got %0d want 16", nstart[1]);
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 6; it++) begin
      int d = it % 2;
      int n = (d == 0) ? 4 : 16;
      logic [31:0] lb = rand_base();
      logic [31:0] rb = rand_base();
      int exp_sad;
      fill_rand(lb, rb, n, 1'b0);
      exp_sad = model_sad(lb, rb, n);
      send_cmd(d, lb, rb);
      wait_result(d, ok);
      checks++;
      if (!ok || rs_w[d] !== 16'(exp_sad) || re_w[d] !== 1'b0) begin
        errors++;
        $display("FAIL random%0d_dut%0d: got sad=%0d err=%b ok=%0d want %0d err=0",
                 it, d, rs_w[d], re_w[d], ok, exp_sad);
      end
      checks++;
      if (nstart[d] != n || seen_l.size() != n ||
          seen_l[n-1] !== lb + 32'(4 * (n - 1)) || seen_r[n-1] !== rb + 32'(4 * (n - 1))) begin
        errors++;
        $display("FAIL random%0d_reads: got %0d pulses want %0d with last addr %h", it,
                 nstart[d], n, lb + 32'(4 * (n - 1)));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] lb = rand_base();
    logic [31:0] rb = rand_base();
    logic [31:0] lb2 = rand_base();
    logic [31:0] rb2 = rand_base();
    int exp1, exp2;
    bit ok;
    fill_rand(lb, rb, 4, 1'b0);
    exp1 = model_sad(lb, rb, 4);
    rr[0] = 1'b0;
    send_cmd(0, lb, rb);
    wait_result(0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_first_timeout: no res_valid"); end
    fill_rand(lb2, rb2, 4, 1'b0);
    exp2 = model_sad(lb2, rb2, 4);
    cv[0] = 1'b1; clb[0] = lb2; crb[0] = rb2;
    for (int c = 0; c < 20; c++) begin
      @(negedge axi_clk);
      checks++;
      if (rv_w[0] !== 1'b1 || rs_w[0] !== 16'(exp1) || cr_w[0] !== 1'b0 || nstart[0] != 4) begin
        errors++;
        $display("FAIL bp_hold_c%0d: got valid=%b sad=%0d ready=%b pulses=%0d want 1/%0d/0/4",
                 c, rv_w[0], rs_w[0], cr_w[0], nstart[0], exp1);
      end
    end
    clear_log(0);
    rr[0] = 1'b1;
    @(negedge axi_clk);
    @(negedge axi_clk);
    cv[0] = 1'b0;
    wait_result(0, ok);
    checks++;
    if (!ok || rs_w[0] !== 16'(exp2) || seen_l.size() == 0 || seen_l[0] !== lb2) begin
      errors++;
      $display("FAIL bp_second_cmd: got sad=%0d ok=%0d want %0d from base %h",
               rs_w[0], ok, exp2, lb2);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] lb = rand_base();
    logic [31:0] rb = rand_base();
    int exp_part;
    bit ok;
    fill_rand(lb, rb, 4, 1'b0);
    exp_part = model_sad(lb, rb, 2);
    withhold = 2;
    send_cmd(0, lb, rb);
    wait_result(0, ok);
    checks++;
    if (!ok || re_w[0] !== 1'b1 || rs_w[0] !== 16'(exp_part)) begin
      errors++;
      $display("FAIL timeout_partial: got err=%b sad=%0d ok=%0d want err=1 sad=%0d",
               re_w[0], rs_w[0], ok, exp_part);
    end
    checks++;
    if (nstart[0] != 3) begin
      errors++;
      $display("FAIL timeout_pulses: got %0d want 3", nstart[0]);
    end
    withhold = -1;
    @(negedge axi_clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] lb = rand_base();
    logic [31:0] rb = rand_base();
    logic [31:0] wl = 32'hFFFF_FFF8;
    logic [31:0] wr = 32'hFFFF_FFF0;
    int exp_sad;
    bit ok;
    fill_rand(lb, rb, 4, 1'b0);
    withhold = 1;
    send_cmd(0, lb, rb);
    for (int c = 0; c < 200 && nstart[0] < 2; c++) @(negedge axi_clk);
    repeat (5) @(negedge axi_clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cr_w[0], busy_w[0], start_w[0], rv_w[0], re_w[0]} !== 5'b10000 ||
        al_w[0] !== 32'h0 || ar_w[0] !== 32'h0 || rs_w[0] !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got flags=%b%b%b%b%b addr=%h/%h sad=%0d want 10000 0/0 0",
               cr_w[0], busy_w[0], start_w[0], rv_w[0], re_w[0], al_w[0], ar_w[0], rs_w[0]);
    end
    withhold = -1;
    @(negedge axi_clk);
    rst_n = 1'b1;
    fill_rand(wl, wr, 4, 1'b0);
    exp_sad = model_sad(wl, wr, 4);
    send_cmd(0, wl, wr);
    wait_result(0, ok);
    checks++;
    if (!ok || rs_w[0] !== 16'(exp_sad) || re_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fresh: got sad=%0d err=%b ok=%0d want %0d err=0",
               rs_w[0], re_w[0], ok, exp_sad);
    end
    checks++;
    if (seen_l.size() != 4 || seen_l[1] !== 32'hFFFF_FFFC || seen_l[2] !== 32'h0 ||
        seen_l[3] !== 32'h4 || seen_r[2] !== 32'hFFFF_FFF8) begin
      errors++;
      $display("FAIL wrap_addr: got %0d reads, l[2]=%h want FFFFFFF8,FFFFFFFC,0,4",
               seen_l.size(), (seen_l.size() > 2) ? seen_l[2] : 32'hx);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      cv[i] = 1'b0; clb[i] = '0; crb[i] = '0; rr[i] = 1'b1;
    end
    test_reset();
    test_basic_w4();
    test_max_w16();
    test_identical();
    test_random();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge axi_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
